// File: rtl/seven_seg_pkg.sv
// Shared constants, FSM state type and digit helpers for the seven-segment controller.
package seven_seg_pkg;

    localparam int NUM_DIGITS = 8;
    localparam logic [6:0] CAT_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } seg_state_e;

    // Index of the most significant nonzero nibble; 0 when the whole value is zero.
    function automatic logic [2:0] top_nonzero_digit(input logic [31:0] value);
        logic [2:0] top;
        top = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (value[k*4 +: 4] != 4'd0) begin
                top = 3'(k);
            end
        end
        return top;
    endfunction

endpackage

// File: rtl/seven_segment_controller_if.sv
// Host-side value load and display-side drive signals of the seven-segment controller.
interface seven_segment_controller_if;

    logic [31:0] val_in;
    logic        valid_in;
    logic [6:0]  cat_out;
    logic [7:0]  an_out;
    logic        frame_out;

    modport master (
        output val_in,
        output valid_in,
        input  cat_out,
        input  an_out,
        input  frame_out
    );

    modport slave (
        input  val_in,
        input  valid_in,
        output cat_out,
        output an_out,
        output frame_out
    );

endinterface

// File: rtl/bin_to_seven_seg.sv
// Hex nibble to active-high segment pattern; bit0 is segment a, bit6 is segment g.
module bin_to_seven_seg (
    input  logic [3:0] bin,
    output logic [6:0] seg
);

    // Combinational hex decode table.
    always_comb begin
        seg = 7'h00;
        case (bin)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/seven_segment_controller.sv
// Eight-digit multiplexed seven-segment driver with frame-aligned value commit.
// Optional build macro LEADING_ZERO_BLANK_EN turns off leading-zero digits.
module seven_segment_controller
    import seven_seg_pkg::*;
#(
    parameter int COUNT_PERIOD = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    seven_segment_controller_if.slave   bus
);

    localparam int CNT_W = $clog2(COUNT_PERIOD);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_next_s;
    logic             slot_wrap_s;
    logic             frame_wrap_s;
    seg_state_e       state_r;
    seg_state_e       state_next_s;
    logic [31:0]      pending_r;
    logic [31:0]      display_r;
    logic [3:0]       nibble_s;
    logic [6:0]       seg_s;
    logic             lit_s;
    logic [6:0]       cat_r;
    logic [6:0]       cat_next_s;
    logic [7:0]       an_r;
    logic [7:0]       an_next_s;
    logic             frame_r;

    // Slot counter and digit index advance; a frame ends when digit 7's slot wraps.
    always_comb begin
        slot_wrap_s  = (cnt_r == CNT_W'(COUNT_PERIOD - 1));
        frame_wrap_s = slot_wrap_s && (idx_r == 3'd7);
        if (slot_wrap_s) begin
            cnt_next_s = '0;
            idx_next_s = idx_r + 3'd1;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
            idx_next_s = idx_r;
        end
    end

    // Next-state logic: each slot opens in BLANK and moves to SHOW once blanking is over.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            BLANK: begin
                if (cnt_next_s >= CNT_W'(BLANK_CYCLES)) begin
                    state_next_s = SHOW;
                end else begin
                    state_next_s = BLANK;
                end
            end
            SHOW: begin
                if (slot_wrap_s) begin
                    state_next_s = BLANK;
                end else begin
                    state_next_s = SHOW;
                end
            end
            default: state_next_s = BLANK;
        endcase
    end

    // Outputs are computed for the upcoming index so anode and pattern switch together.
    assign nibble_s = display_r[{idx_next_s, 2'b00} +: 4];

    bin_to_seven_seg u_dec (
        .bin (nibble_s),
        .seg (seg_s)
    );

`ifdef LEADING_ZERO_BLANK_EN
    // Digit 0 always qualifies because the top-digit index is never below 0.
    always_comb begin
        lit_s = (idx_next_s <= top_nonzero_digit(display_r));
    end
`else
    assign lit_s = 1'b1;
`endif

    // Anode and cathode drive for the upcoming cycle.
    always_comb begin
        an_next_s  = AN_OFF;
        cat_next_s = CAT_OFF;
        case (state_next_s)
            BLANK: begin
                an_next_s  = AN_OFF;
                cat_next_s = CAT_OFF;
            end
            SHOW: begin
                if (lit_s) begin
                    an_next_s  = ~(8'd1 << idx_next_s);
                    cat_next_s = ~seg_s;
                end else begin
                    an_next_s  = AN_OFF;
                    cat_next_s = CAT_OFF;
                end
            end
            default: begin
                an_next_s  = AN_OFF;
                cat_next_s = CAT_OFF;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r <= BLANK;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath registers: counters, value staging and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_r     <= '0;
            idx_r     <= 3'd0;
            pending_r <= 32'd0;
            display_r <= 32'd0;
            an_r      <= AN_OFF;
            cat_r     <= CAT_OFF;
            frame_r   <= 1'b0;
        end else begin
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            an_r    <= an_next_s;
            cat_r   <= cat_next_s;
            frame_r <= frame_wrap_s;
            if (bus.valid_in) begin
                pending_r <= bus.val_in;
            end
            // Commit sees the pre-edge pending, so a same-edge load waits a frame.
            if (frame_wrap_s) begin
                display_r <= pending_r;
            end
        end
    end

    assign bus.cat_out   = cat_r;
    assign bus.an_out    = an_r;
    assign bus.frame_out = frame_r;

endmodule

// File: tb/tb_seven_segment_controller.sv
// Directed self-checking bench for seven_segment_controller (COUNT_PERIOD=32, BLANK_CYCLES=4).
module tb_seven_segment_controller;

    localparam int CP    = 32;
    localparam int BC    = 4;
    localparam int FRAME = 8 * CP;

    logic clk_in;
    logic rst_in;
    int   vectors;
    int   errors;

    seven_segment_controller_if bus ();

    seven_segment_controller #(
        .COUNT_PERIOD (CP),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    function automatic logic [6:0] seg_inv(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    function automatic logic lit_m(input int k, input logic [31:0] v);
        logic r;
        r = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        r = (k == 0);
        for (int m = k; m < 8; m++) begin
            if (v[m*4 +: 4] != 4'h0) r = 1'b1;
        end
`endif
        return r;
    endfunction

    // Expected anodes j cycles after the frame_out cycle.
    function automatic logic [7:0] exp_an(input int j, input logic [31:0] v);
        logic [7:0] a;
        int k;
        k = j / CP;
        if ((j % CP) < BC || !lit_m(k, v)) return 8'hFF;
        a = 8'h01 << k;
        return ~a;
    endfunction

    function automatic logic [6:0] exp_cat(input int j, input logic [31:0] v);
        int k;
        k = j / CP;
        if ((j % CP) < BC || !lit_m(k, v)) return 7'h7F;
        return seg_inv(v[k*4 +: 4]);
    endfunction

    task automatic send(input logic [31:0] v);
        bus.val_in   = v;
        bus.valid_in = 1'b1;
        @(negedge clk_in);
        bus.valid_in = 1'b0;
    endtask

    // Advances to the next cycle showing frame_out, bounded.
    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (bus.frame_out !== 1'b1 && n < 600);
        vectors++;
        if (bus.frame_out !== 1'b1) begin
            errors++;
            $display("FAIL wait_frame: frame_out=%b after %0d cycles, required 1", bus.frame_out, n);
        end
    endtask

    task automatic test_reset();
        rst_in       = 1'b1;
        bus.valid_in = 1'b0;
        bus.val_in   = 32'h0;
        repeat (3) @(negedge clk_in);
        vectors++;
        if (bus.an_out !== 8'hFF || bus.cat_out !== 7'h7F || bus.frame_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%h cat=%h frame=%b, required FF 7F 0", bus.an_out, bus.cat_out, bus.frame_out);
        end
        rst_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_in);
            vectors++;
            if (bus.an_out !== 8'hFF || bus.cat_out !== 7'h7F) begin
                errors++;
                $display("FAIL reset_blank%0d: an=%h cat=%h, required FF 7F", i, bus.an_out, bus.cat_out);
            end
        end
        @(negedge clk_in);
        vectors++;
        if (bus.an_out !== 8'hFE || bus.cat_out !== 7'h40) begin
            errors++;
            $display("FAIL reset_first_show: an=%h cat=%h, required FE 40", bus.an_out, bus.cat_out);
        end
    endtask

    task automatic test_frame_commit();
        send(32'h0000_0001);
        vectors++;
        if (bus.an_out !== 8'hFE || bus.cat_out !== 7'h40) begin
            errors++;
            $display("FAIL precommit_old_value: an=%h cat=%h, required FE 40", bus.an_out, bus.cat_out);
        end
        wait_frame();
        repeat (3) @(negedge clk_in);
        vectors++;
        if (bus.an_out !== 8'hFF || bus.frame_out !== 1'b0) begin
            errors++;
            $display("FAIL commit_blank: an=%h frame=%b, required FF 0", bus.an_out, bus.frame_out);
        end
        @(negedge clk_in);
        vectors++;
        if (bus.an_out !== 8'hFE || bus.cat_out !== 7'h79) begin
            errors++;
            $display("FAIL commit_digit0: an=%h cat=%h, required FE 79", bus.an_out, bus.cat_out);
        end
    endtask

    task automatic test_walk();
        logic [31:0] v;
        v = 32'h7654_3210;
        wait_frame();
        send(v);
        wait_frame();
        for (int j = 1; j < FRAME; j++) begin
            @(negedge clk_in);
            vectors++;
            if (bus.an_out !== exp_an(j, v) || bus.cat_out !== exp_cat(j, v)) begin
                errors++;
                $display("FAIL walk j=%0d: an=%h cat=%h, required %h %h", j, bus.an_out, bus.cat_out, exp_an(j, v), exp_cat(j, v));
            end
        end
    endtask

    task automatic test_no_tear();
        logic [31:0] va;
        logic [31:0] vb;
        va = 32'hAAAA_AAAA;
        vb = 32'h5555_5555;
        wait_frame();
        for (int j = 1; j <= 100; j++) @(negedge clk_in);
        send(va);
        for (int j = 102; j <= 234; j++) @(negedge clk_in);
        vectors++;
        if (bus.an_out !== 8'h7F || bus.cat_out !== 7'h78) begin
            errors++;
            $display("FAIL no_tear_old_digit7: an=%h cat=%h, required 7F 78", bus.an_out, bus.cat_out);
        end
        for (int j = 235; j <= 255; j++) @(negedge clk_in);
        bus.val_in   = vb;
        bus.valid_in = 1'b1;
        @(negedge clk_in);
        bus.valid_in = 1'b0;
        vectors++;
        if (bus.frame_out !== 1'b1) begin
            errors++;
            $display("FAIL no_tear_frame1: frame=%b, required 1", bus.frame_out);
        end
        for (int j = 1; j < FRAME; j++) begin
            @(negedge clk_in);
            vectors++;
            if (bus.an_out !== exp_an(j, va) || bus.cat_out !== exp_cat(j, va)) begin
                errors++;
                $display("FAIL no_tear_A j=%0d: an=%h cat=%h, required %h %h", j, bus.an_out, bus.cat_out, exp_an(j, va), exp_cat(j, va));
            end
        end
        @(negedge clk_in);
        vectors++;
        if (bus.frame_out !== 1'b1) begin
            errors++;
            $display("FAIL no_tear_frame2: frame=%b, required 1", bus.frame_out);
        end
        for (int j = 1; j < FRAME; j++) begin
            @(negedge clk_in);
            vectors++;
            if (bus.an_out !== exp_an(j, vb) || bus.cat_out !== exp_cat(j, vb)) begin
                errors++;
                $display("FAIL no_tear_5 j=%0d: an=%h cat=%h, required %h %h", j, bus.an_out, bus.cat_out, exp_an(j, vb), exp_cat(j, vb));
            end
        end
    endtask

    task automatic test_lead_zero();
        logic [31:0] v;
        for (int t = 0; t < 2; t++) begin
            v = (t == 0) ? 32'h0000_00F3 : 32'h0000_0000;
            wait_frame();
            send(v);
            wait_frame();
            for (int j = 1; j < FRAME; j++) begin
                @(negedge clk_in);
                vectors++;
                if (bus.an_out !== exp_an(j, v) || bus.cat_out !== exp_cat(j, v)) begin
                    errors++;
                    $display("FAIL lead_zero v=%h j=%0d: an=%h cat=%h, required %h %h", v, j, bus.an_out, bus.cat_out, exp_an(j, v), exp_cat(j, v));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_frame();
        send(32'h0050_0000);
        wait_frame();
        repeat (170) @(negedge clk_in);
        vectors++;
        if (bus.an_out !== 8'hDF || bus.cat_out !== 7'h12) begin
            errors++;
            $display("FAIL mid_digit5: an=%h cat=%h, required DF 12", bus.an_out, bus.cat_out);
        end
        rst_in       = 1'b1;
        bus.val_in   = 32'hFFFF_FFFF;
        bus.valid_in = 1'b1;
        @(negedge clk_in);
        rst_in       = 1'b0;
        bus.valid_in = 1'b0;
        vectors++;
        if (bus.an_out !== 8'hFF || bus.cat_out !== 7'h7F || bus.frame_out !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: an=%h cat=%h frame=%b, required FF 7F 0", bus.an_out, bus.cat_out, bus.frame_out);
        end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk_in);
            vectors++;
            if (bus.an_out !== 8'hFF) begin
                errors++;
                $display("FAIL mid_reset_blank%0d: an=%h, required FF", i, bus.an_out);
            end
        end
        @(negedge clk_in);
        vectors++;
        if (bus.an_out !== 8'hFE || bus.cat_out !== 7'h40) begin
            errors++;
            $display("FAIL mid_reset_digit0: an=%h cat=%h, required FE 40", bus.an_out, bus.cat_out);
        end
        wait_frame();
        repeat (4) @(negedge clk_in);
        vectors++;
        if (bus.an_out !== 8'hFE || bus.cat_out !== 7'h40) begin
            errors++;
            $display("FAIL reset_valid_ignored: an=%h cat=%h, required FE 40", bus.an_out, bus.cat_out);
        end
    endtask

    task automatic test_free_run();
        int period;
        wait_frame();
        for (int f = 0; f < 3; f++) begin
            period = 0;
            do begin
                @(negedge clk_in);
                period++;
                vectors++;
                if ($countones(~bus.an_out) > 1) begin
                    errors++;
                    $display("FAIL free_run_onehot: an=%h, required at most one low bit", bus.an_out);
                end
            end while (bus.frame_out !== 1'b1 && period < 600);
            vectors++;
            if (period !== FRAME) begin
                errors++;
                $display("FAIL free_run_period f=%0d: %0d cycles, required %0d", f, period, FRAME);
            end
        end
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_frame_commit();
        test_walk();
        test_no_tear();
        test_lead_zero();
        test_reset_mid();
        test_free_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
